// File: rtl/lhist_bht.sv
// lhist_bht: set-associative branch history table with per-entry local
// history selecting one of 2^BH_BITS saturating counters per entry.
// Optional feature macro: LHIST_BHT_BYPASS_EN (forward the in-flight update
// to a same-cycle prediction of the same entry).
module lhist_bht #(
    parameter int ASSOCIATIVITY = 2,
    parameter int SET_NUM       = 16,
    parameter int BH_BITS       = 2,
    parameter int COUNTER_BITS  = 2,
    parameter int TAG_BITS      = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pred_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic        upd_taken,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,
    output logic        init_busy
);

    localparam int IB = $clog2(SET_NUM);
    localparam int WB = $clog2(ASSOCIATIVITY);
    localparam int NC = 1 << BH_BITS;
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK_T  = {1'b1, {(COUNTER_BITS-1){1'b0}}};
    localparam logic [COUNTER_BITS-1:0] CTR_WEAK_NT = {1'b0, {(COUNTER_BITS-1){1'b1}}};
    localparam logic [COUNTER_BITS-1:0] CTR_MAX     = {COUNTER_BITS{1'b1}};

    typedef enum logic {INIT, READY} state_e;

    state_e            state_q, state_d;
    logic [IB-1:0]     init_idx_q, init_idx_d;

    logic              pend_valid_q, pend_valid_d;
    logic              pend_taken_q, pend_taken_d;
    logic [IB-1:0]     pend_idx_q, pend_idx_d;
    logic [TAG_BITS-1:0] pend_tag_q, pend_tag_d;
    logic [31:0]       pend_target_q, pend_target_d;

    logic                    valid_q  [SET_NUM][ASSOCIATIVITY];
    logic [TAG_BITS-1:0]     tag_q    [SET_NUM][ASSOCIATIVITY];
    logic [31:0]             target_q [SET_NUM][ASSOCIATIVITY];
    logic [BH_BITS-1:0]      bhr_q    [SET_NUM][ASSOCIATIVITY];
    logic [COUNTER_BITS-1:0] ctr_q    [SET_NUM][ASSOCIATIVITY][NC];
    logic [WB-1:0]           ptr_q    [SET_NUM];

    logic [IB-1:0]       pred_idx;
    logic [TAG_BITS-1:0] pred_tag;
    logic                unused_pc_bits;

    // Only the index and tag fields of the PCs take part in the lookup.
    assign pred_idx       = pred_pc[IB+1:2];
    assign pred_tag       = pred_pc[IB+TAG_BITS+1:IB+2];
    assign unused_pc_bits = ^{pred_pc, upd_pc};
    assign init_busy      = (state_q == INIT);

    // Sweep FSM plus the pending-update slot; updates are dropped while sweeping.
    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        pend_valid_d  = upd_valid && (state_q == READY);
        pend_taken_d  = upd_taken;
        pend_idx_d    = upd_pc[IB+1:2];
        pend_tag_d    = upd_pc[IB+TAG_BITS+1:IB+2];
        pend_target_d = upd_target;
        case (state_q)
            INIT: begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == IB'(SET_NUM - 1)) begin
                    state_d    = READY;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d = READY;
            end
        endcase
    end

    // Control state register; reset restarts the sweep and discards any pending update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= INIT;
            init_idx_q    <= '0;
            pend_valid_q  <= 1'b0;
            pend_taken_q  <= 1'b0;
            pend_idx_q    <= '0;
            pend_tag_q    <= '0;
            pend_target_q <= '0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_taken_q  <= pend_taken_d;
            pend_idx_q    <= pend_idx_d;
            pend_tag_q    <= pend_tag_d;
            pend_target_q <= pend_target_d;
        end
    end

    logic                    upd_hit, inv_found;
    logic [WB-1:0]           upd_way, victim_way, way_sel, new_ptr;
    logic [31:0]             new_target;
    logic [BH_BITS-1:0]      new_bhr, old_bhr;
    logic [BH_BITS:0]        hist_ext;
    logic [COUNTER_BITS-1:0] cur_ctr;
    logic [COUNTER_BITS-1:0] new_ctr [NC];

    // Look up the pending update and build the entry written at the end of this cycle.
    always_comb begin
        upd_hit    = 1'b0;
        upd_way    = '0;
        inv_found  = 1'b0;
        victim_way = ptr_q[pend_idx_q];
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (valid_q[pend_idx_q][w] && (tag_q[pend_idx_q][w] == pend_tag_q)) begin
                upd_hit = 1'b1;
                upd_way = WB'(w);
            end
            if (!valid_q[pend_idx_q][w]) begin
                inv_found  = 1'b1;
                victim_way = WB'(w);
            end
        end
        way_sel  = upd_hit ? upd_way : victim_way;
        new_ptr  = ptr_q[pend_idx_q];
        old_bhr  = bhr_q[pend_idx_q][way_sel];
        hist_ext = {old_bhr, pend_taken_q};
        cur_ctr  = ctr_q[pend_idx_q][way_sel][old_bhr];
        for (int c = 0; c < NC; c++) begin
            new_ctr[c] = ctr_q[pend_idx_q][way_sel][c];
        end
        if (upd_hit) begin
            new_target = pend_taken_q ? pend_target_q : target_q[pend_idx_q][way_sel];
            new_bhr    = hist_ext[BH_BITS-1:0];
            if (pend_taken_q && (cur_ctr != CTR_MAX)) begin
                new_ctr[old_bhr] = cur_ctr + 1'b1;
            end else if (!pend_taken_q && (cur_ctr != '0)) begin
                new_ctr[old_bhr] = cur_ctr - 1'b1;
            end
        end else begin
            new_target = pend_target_q;
            new_bhr    = {BH_BITS{pend_taken_q}};
            for (int c = 0; c < NC; c++) begin
                new_ctr[c] = pend_taken_q ? CTR_WEAK_T : CTR_WEAK_NT;
            end
            if (!inv_found) begin
                new_ptr = ptr_q[pend_idx_q] + 1'b1;
            end
        end
    end

    // Table storage: the sweep clears one set per cycle, otherwise commit the pending update.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            for (int w = 0; w < ASSOCIATIVITY; w++) begin
                valid_q[init_idx_q][w] <= 1'b0;
            end
            ptr_q[init_idx_q] <= '0;
        end else if (pend_valid_q) begin
            valid_q[pend_idx_q][way_sel]  <= 1'b1;
            tag_q[pend_idx_q][way_sel]    <= pend_tag_q;
            target_q[pend_idx_q][way_sel] <= new_target;
            bhr_q[pend_idx_q][way_sel]    <= new_bhr;
            for (int c = 0; c < NC; c++) begin
                ctr_q[pend_idx_q][way_sel][c] <= new_ctr[c];
            end
            ptr_q[pend_idx_q] <= new_ptr;
        end
    end

    logic          arr_hit;
    logic [WB-1:0] arr_way;

    // Combinational prediction; the lowest matching way wins, nothing is reported while sweeping.
    always_comb begin
        arr_hit     = 1'b0;
        arr_way     = '0;
        pred_hit    = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
            if (valid_q[pred_idx][w] && (tag_q[pred_idx][w] == pred_tag)) begin
                arr_hit = 1'b1;
                arr_way = WB'(w);
            end
        end
        if (state_q == READY) begin
            if (arr_hit) begin
                pred_hit    = 1'b1;
                pred_taken  = ctr_q[pred_idx][arr_way][bhr_q[pred_idx][arr_way]][COUNTER_BITS-1];
                pred_target = target_q[pred_idx][arr_way];
            end
`ifdef LHIST_BHT_BYPASS_EN
            if (pend_valid_q && (pred_idx == pend_idx_q) && (pred_tag == pend_tag_q)) begin
                pred_hit    = 1'b1;
                pred_taken  = new_ctr[new_bhr][COUNTER_BITS-1];
                pred_target = new_target;
            end
`else
            if (pend_valid_q && (pred_idx == pend_idx_q) && (pred_tag == pend_tag_q)) begin
                pred_hit = arr_hit;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lhist_bht.sv
// tb_lhist_bht: directed self-checking bench for lhist_bht (default parameters).
module tb_lhist_bht;

    logic        clk;
    logic        reset;
    logic [31:0] pred_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic        upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        init_busy;

    int checks;
    int passes;

    lhist_bht dut (
        .clk         (clk),
        .reset       (reset),
        .pred_pc     (pred_pc),
        .pred_hit    (pred_hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_taken   (upd_taken),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .init_busy   (init_busy)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one update for exactly one rising edge.
    task automatic send_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        tick();
        upd_valid  = 1'b0;
    endtask

    task automatic set_pred(input logic [31:0] pc);
        pred_pc = pc;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (init_busy !== 1'b1) $display("[TB] FAIL reset_busy got %0b want 1", init_busy);
        else passes++;
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== 34'd0)
            $display("[TB] FAIL reset_outputs got hit=%0b taken=%0b tgt=%h want 0/0/0", pred_hit, pred_taken, pred_target);
        else passes++;
        reset = 1'b0;
    endtask

    task automatic test_init_sweep();
        int  n;
        bit  saw_hit;
        n       = 0;
        saw_hit = 1'b0;
        pred_pc    = 32'h8000_1014;
        upd_valid  = 1'b1;
        upd_pc     = 32'h8000_1014;
        upd_taken  = 1'b1;
        upd_target = 32'h8000_AAAA;
        #1;
        while (init_busy === 1'b1 && n < 40) begin
            if (pred_hit !== 1'b0) saw_hit = 1'b1;
            n++;
            tick();
        end
        upd_valid = 1'b0;
        checks++;
        if (n !== 16) $display("[TB] FAIL sweep_length got %0d want 16", n);
        else passes++;
        checks++;
        if (saw_hit !== 1'b0) $display("[TB] FAIL sweep_pred_hit got 1 want 0");
        else passes++;
        tick();
        tick();
        set_pred(32'h8000_1014);
        checks++;
        if (pred_hit !== 1'b0) $display("[TB] FAIL sweep_upd_dropped got hit=%0b want 0", pred_hit);
        else passes++;
    endtask

    task automatic test_alloc_predict();
        send_update(32'h8000_1000, 1'b1, 32'h8000_2000);
        tick();
        set_pred(32'h8000_1000);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h8000_2000})
            $display("[TB] FAIL alloc_predict got hit=%0b taken=%0b tgt=%h want 1/1/80002000", pred_hit, pred_taken, pred_target);
        else passes++;
    endtask

    task automatic test_history();
        logic exp_taken [5];
        exp_taken = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            send_update(32'h8000_1000, 1'b0, 32'h8000_2000);
            tick();
            set_pred(32'h8000_1000);
            checks++;
            if ({pred_hit, pred_taken} !== {1'b1, exp_taken[i]})
                $display("[TB] FAIL history_nt%0d got hit=%0b taken=%0b want 1/%0b", i + 1, pred_hit, pred_taken, exp_taken[i]);
            else passes++;
        end
    endtask

    task automatic test_saturation_target();
        send_update(32'h8000_1004, 1'b1, 32'h8000_3000);
        tick();
        send_update(32'h8000_1004, 1'b1, 32'h8000_4000);
        tick();
        send_update(32'h8000_1004, 1'b1, 32'h8000_4000);
        tick();
        set_pred(32'h8000_1004);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h8000_4000})
            $display("[TB] FAIL sat_high got hit=%0b taken=%0b tgt=%h want 1/1/80004000", pred_hit, pred_taken, pred_target);
        else passes++;
        send_update(32'h8000_1004, 1'b0, 32'h8000_5000);
        tick();
        set_pred(32'h8000_1004);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h8000_4000})
            $display("[TB] FAIL nt_keeps_target got hit=%0b taken=%0b tgt=%h want 1/1/80004000", pred_hit, pred_taken, pred_target);
        else passes++;
    endtask

    task automatic test_back_to_back();
        send_update(32'h8000_1008, 1'b1, 32'h8000_6000);
        send_update(32'h8000_1008, 1'b0, 32'h0000_0000);
        send_update(32'h8000_1008, 1'b0, 32'h0000_0000);
        send_update(32'h8000_1008, 1'b0, 32'h0000_0000);
        tick();
        set_pred(32'h8000_1008);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b0, 32'h8000_6000})
            $display("[TB] FAIL back_to_back got hit=%0b taken=%0b tgt=%h want 1/0/80006000", pred_hit, pred_taken, pred_target);
        else passes++;
    endtask

    task automatic test_replacement();
        send_update(32'h8001_1000, 1'b1, 32'h8000_7000);
        tick();
        send_update(32'h8002_1000, 1'b1, 32'h8000_8000);
        tick();
        set_pred(32'h8000_1000);
        checks++;
        if ({pred_hit, pred_taken, pred_target} !== 34'd0)
            $display("[TB] FAIL evicted_way0 got hit=%0b taken=%0b tgt=%h want 0/0/0", pred_hit, pred_taken, pred_target);
        else passes++;
        set_pred(32'h8001_1000);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h8000_7000})
            $display("[TB] FAIL kept_way1 got hit=%0b tgt=%h want 1/80007000", pred_hit, pred_target);
        else passes++;
        set_pred(32'h8002_1000);
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h8000_8000})
            $display("[TB] FAIL new_way0 got hit=%0b tgt=%h want 1/80008000", pred_hit, pred_target);
        else passes++;
    endtask

    task automatic test_bypass();
        send_update(32'h8000_100C, 1'b1, 32'h8000_9000);
        set_pred(32'h8000_100C);
        checks++;
`ifdef LHIST_BHT_BYPASS_EN
        if ({pred_hit, pred_taken, pred_target} !== {1'b1, 1'b1, 32'h8000_9000})
            $display("[TB] FAIL bypass_n1 got hit=%0b taken=%0b tgt=%h want 1/1/80009000", pred_hit, pred_taken, pred_target);
        else passes++;
`else
        if (pred_hit !== 1'b0) $display("[TB] FAIL no_bypass_n1 got hit=%0b want 0", pred_hit);
        else passes++;
`endif
        tick();
        checks++;
        if ({pred_hit, pred_target} !== {1'b1, 32'h8000_9000})
            $display("[TB] FAIL bypass_n2 got hit=%0b tgt=%h want 1/80009000", pred_hit, pred_target);
        else passes++;
    endtask

    task automatic test_reset_pending();
        int n;
        send_update(32'h8000_1010, 1'b1, 32'h8000_B000);
        reset = 1'b1;
        set_pred(32'h8000_100C);
        checks++;
        if ({init_busy, pred_hit, pred_taken, pred_target} !== {1'b1, 34'd0})
            $display("[TB] FAIL reset_async got busy=%0b hit=%0b taken=%0b tgt=%h want 1/0/0/0", init_busy, pred_hit, pred_taken, pred_target);
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        n = 0;
        while (init_busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 16) $display("[TB] FAIL restart_sweep_length got %0d want 16", n);
        else passes++;
        set_pred(32'h8000_1010);
        checks++;
        if (pred_hit !== 1'b0) $display("[TB] FAIL pending_discarded got hit=%0b want 0", pred_hit);
        else passes++;
        set_pred(32'h8000_100C);
        checks++;
        if (pred_hit !== 1'b0) $display("[TB] FAIL table_cleared got hit=%0b want 0", pred_hit);
        else passes++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        pred_pc    = 32'h0;
        upd_valid  = 1'b0;
        upd_taken  = 1'b0;
        upd_pc     = 32'h0;
        upd_target = 32'h0;
        test_reset();
        test_init_sweep();
        test_alloc_predict();
        test_history();
        test_saturation_target();
        test_back_to_back();
        test_replacement();
        test_bypass();
        test_reset_pending();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lhist_bht.md
LHIST_BHT -- requirements
Module: lhist_bht

Interface
REQ-001 SHALL expose parameter ASSOCIATIVITY, default 2, ways per set; power of two, at least 2.
REQ-002 SHALL expose parameter SET_NUM, default 16, sets; power of two, at least 2; IB = log2(SET_NUM).
REQ-003 SHALL expose parameter BH_BITS, default 2, per-entry local history width; at least 1.
REQ-004 SHALL expose parameter COUNTER_BITS, default 2, saturating counter width; at least 2.
REQ-005 SHALL expose parameter TAG_BITS, default 18, tag width.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port pred_pc  in  32  PC to predict.
REQ-009 SHALL have port pred_hit, pred_taken  out  1 each  lookup hit; predicted direction.
REQ-010 SHALL have port pred_target  out  32  predicted target; 0 on miss.
REQ-011 SHALL have port upd_valid, upd_taken  in  1 each  resolved-branch update strobe; outcome.
REQ-012 SHALL have port upd_pc, upd_target  in  32 each  resolved branch PC; resolved target.
REQ-013 SHALL have port init_busy  out  1  table sweep in progress.

Function
REQ-014 Index SHALL be pc[IB+1:2]; tag SHALL be pc[IB+TAG_BITS+1:IB+2].
REQ-015 Each entry SHALL hold valid, tag, target, bhr[BH_BITS], and 2^BH_BITS counters.
- Each set SHALL also hold a round-robin pointer.
REQ-016 Prediction SHALL be combinational, 0 cycles.
- On a hit, pred_taken = MSB of counter[bhr].
- If several ways match, the lowest way SHALL win.
REQ-017 Updates SHALL be two-stage.
- Cycle N: upd_* SHALL be registered into a pending slot.
- Cycle N+1: the pending entry SHALL be looked up and the new entry computed.
- The array SHALL be written at the end of N+1.
- Back-to-back updates to one entry SHALL therefore see each other.
REQ-018 A hit update SHALL do the following:
- counter[bhr] saturating increment if taken, decrement if not taken.
- bhr = {bhr[BH_BITS-2:0], taken}; when BH_BITS=1, bhr = taken.
- target replaced only if taken.
REQ-019 A miss update SHALL allocate a way:
- victim: first invalid way, else the pointer's way; the pointer SHALL advance mod ASSOCIATIVITY only when evicting.
- new entry: valid=1, tag, target=upd_target.
- bhr all-ones if taken, else zero.
- all counters 2^(COUNTER_BITS-1) if taken, else 2^(COUNTER_BITS-1)-1.
REQ-020 FSM states SHALL be INIT and READY.
- INIT SHALL clear valid and pointer for one set per cycle, sets 0..SET_NUM-1.
- After SET_NUM cycles the FSM SHALL move to READY.
REQ-021 While INIT, init_busy=1, pred_hit=0, and upd_valid SHALL be dropped.
REQ-022 Counter saturation SHALL hold at 0 and at 2^COUNTER_BITS-1 with no wrap.

Reset
REQ-023 reset SHALL force INIT at set 0, clear the pending slot, set init_busy=1, and drive pred_hit=0, pred_taken=0, pred_target=0.
REQ-024 reset asserted mid-sweep or with an update pending SHALL restart the sweep and discard the pending update.

Configuration
REQ-025 Macro LHIST_BHT_BYPASS_EN defined: prediction in cycle N+1 SHALL return the computed new entry when pred_pc index and tag match the pending update.
- This includes a just-allocated entry.
REQ-026 Macro LHIST_BHT_BYPASS_EN undefined: prediction SHALL read array contents only and see an update from cycle N first in cycle N+2.

Verification (defaults, SET_NUM=16)
REQ-027 Release reset -> init_busy=1 for exactly 16 cycles, pred_hit=0 throughout; an upd_valid sent during that time has no effect.
REQ-028 Allocate and predict:
- stimulus: upd pc=0x80001000, taken=1, target=0x80002000; predict 0x80001000 two cycles later.
- response: pred_hit=1, pred_taken=1, pred_target=0x80002000.
REQ-029 History, same pc:
- 1 not-taken update -> pred_taken=1 (bhr=10, counter[10]=2).
- 2 more not-taken updates -> pred_taken=0 (bhr=00, counter[00]=1).
- further not-taken updates -> counter[00] holds at 0.
REQ-030 Replacement:
- stimulus: allocate 0x80001000, 0x80011000, 0x80021000 (same set 0).
- response: third evicts way 0; 0x80001000 misses; the other two hit.
REQ-031 Bypass timing: update in cycle N, predict same pc in N+1.
- macro defined -> pred_hit=1.
- macro undefined -> pred_hit=0 in N+1, pred_hit=1 in N+2.
REQ-032 Reset with an update pending -> after the 16-cycle sweep, predicting that pc gives pred_hit=0.
